// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: latches a decode copy in FETCH, then walks the
// datapath through one phase per cycle, with a timed data-memory handshake.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        dataReady,
  output logic        pcEn,
  output logic        instrLatchEn,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic        dataReq,
  output logic        dataWe,
  output logic        RFWDSrcMuxSel,
  output logic        branch,
  output logic        illegalInstr,
  output logic        memErr
);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXE, I_EXE, B_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB
  } state_t;

  state_t      state_q;
  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q;
  logic        funct7b5_q;
  logic [7:0]  waitCnt_q;
  logic        timeout;
  logic        unusedInstrBits;

  // Only opcode, funct3 and funct7[5] steer this sequencer; the rest belongs to the datapath.
  assign unusedInstrBits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  assign timeout = (waitCnt_q == LAST_WAIT) && !dataReady;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= FETCH;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      waitCnt_q  <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          opcode_q   <= instrCode[6:0];
          funct3_q   <= instrCode[14:12];
          funct7b5_q <= instrCode[30];
          state_q    <= DECODE;
        end
        DECODE: begin
          case (opcode_q)
            OP_R:    state_q <= R_EXE;
            OP_I:    state_q <= I_EXE;
            OP_B:    state_q <= B_EXE;
            OP_S:    state_q <= S_EXE;
            OP_L:    state_q <= L_EXE;
            default: state_q <= FETCH;
          endcase
        end
        S_EXE: begin
          waitCnt_q <= '0;
          state_q   <= S_MEM;
        end
        L_EXE: begin
          waitCnt_q <= '0;
          state_q   <= L_MEM;
        end
        S_MEM: begin
          if (dataReady || timeout) state_q <= FETCH;
          else                      waitCnt_q <= waitCnt_q + 8'd1;
        end
        // A timed-out load skips write-back entirely so no stale data lands in the register file.
        L_MEM: begin
          if (dataReady)    state_q <= L_WB;
          else if (timeout) state_q <= FETCH;
          else              waitCnt_q <= waitCnt_q + 8'd1;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  always_comb begin
    pcEn          = 1'b0;
    instrLatchEn  = 1'b0;
    regFileWe     = 1'b0;
    aluControl    = 4'b0000;
    aluSrcMuxSel  = 1'b0;
    dataReq       = 1'b0;
    dataWe        = 1'b0;
    RFWDSrcMuxSel = 1'b0;
    branch        = 1'b0;
    illegalInstr  = 1'b0;
    memErr        = 1'b0;
    if (reset) begin
      unique case (state_q)
        FETCH: instrLatchEn = 1'b1;
        DECODE: begin
          if (!(opcode_q inside {OP_R, OP_I, OP_B, OP_S, OP_L})) begin
            illegalInstr = 1'b1;
            pcEn         = 1'b1;
          end
        end
        R_EXE: begin
          regFileWe  = 1'b1;
          pcEn       = 1'b1;
          aluControl = {funct7b5_q, funct3_q};
        end
        // funct7[5] only distinguishes SRAI from SRLI; other immediates reuse those bits as data.
        I_EXE: begin
          regFileWe    = 1'b1;
          aluSrcMuxSel = 1'b1;
          pcEn         = 1'b1;
          aluControl   = (funct3_q == 3'b101) ? {funct7b5_q, funct3_q} : {1'b0, funct3_q};
        end
        B_EXE: begin
          branch     = 1'b1;
          pcEn       = 1'b1;
          aluControl = {1'b0, funct3_q};
        end
        S_EXE, L_EXE: aluSrcMuxSel = 1'b1;
        S_MEM: begin
          dataReq      = 1'b1;
          dataWe       = 1'b1;
          aluSrcMuxSel = 1'b1;
          pcEn         = dataReady || timeout;
          memErr       = timeout;
        end
        L_MEM: begin
          dataReq      = 1'b1;
          aluSrcMuxSel = 1'b1;
          pcEn         = timeout;
          memErr       = timeout;
        end
        L_WB: begin
          regFileWe     = 1'b1;
          RFWDSrcMuxSel = 1'b1;
          pcEn          = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
